// File: rtl/vlsu_data_responder_pkg.sv
// Shared types for the vector LSU data-port responder: response FIFO entry
// layout and the 16-bit LFSR used for random latency / grant stalls.
package vlsu_data_responder_pkg;

  typedef struct packed {
    logic        is_write;
    logic [31:0] data;
    logic [2:0]  lat;
    logic [2:0]  age;
  } resp_entry_t;

  // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/vlsu_resp_fifo.sv
// In-order response FIFO; every entry ages once per cycle and the head reports
// when it must be issued so that rvalid lands exactly on its target latency.
module vlsu_resp_fifo
  import vlsu_data_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        head_expired,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  resp_entry_t     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage carries no reset; ages saturate so stale slots never wrap
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (push && (wr_ptr == AW'(k))) begin
        mem[k]     <= push_entry;
        mem[k].age <= 3'd0;
      end else if (mem[k].age != 3'd7) begin
        mem[k].age <= mem[k].age + 3'd1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Popping now puts rvalid in the next cycle, when the head's age will be age+1
  assign head_expired = !empty && (({1'b0, head.age} + 4'd2) >= {1'b0, head.lat});

endmodule

// File: rtl/vlsu_data_responder.sv
// Slave end of the vector LSU data port: word-addressed RAM with configurable
// response latency, optional random latency/grant stalls and bounded outstanding.
module vlsu_data_responder
  import vlsu_data_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned MIN_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RANDOM_LAT      = 0,
  parameter int unsigned RANDOM_GNT      = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        stall_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [15:0]      lfsr_q;
  logic             run_q;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_expired;
  logic             push;
  logic             bypass;
  logic [2:0]       lat_new;
  resp_entry_t      new_entry;
  resp_entry_t      head;
  logic             rsp_vld_p0;
  logic [31:0]      rsp_data_p0;
  logic             rsp_vld_p1;
  logic [31:0]      rsp_data_p1;
  logic             unused_ok;

  assign idx    = data_addr_i[IDX_W+1:2];
  assign accept = data_req_i & data_gnt_o;

  // run_q keeps gnt low while reset is held and for the first edge after release
  assign data_gnt_o = data_req_i & run_q & ~stall_i & ~fifo_full &
                      ~((RANDOM_GNT != 0) & lfsr_q[0]);

  assign lat_new = 3'(MIN_LATENCY) + {1'b0, (RANDOM_LAT != 0) ? lfsr_q[2:1] : 2'd0};

  always_comb begin
    new_entry          = '0;
    new_entry.is_write = data_we_i;
    new_entry.data     = data_we_i ? 32'd0 : mem[idx];
    new_entry.lat      = lat_new;
  end

  // A latency-1 accept into an empty queue must answer on the very next cycle
  assign bypass = accept & fifo_empty & (lat_new == 3'd1);
  assign push   = accept & ~bypass;

  always_ff @(posedge clk) begin
    if (accept && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
      end
    end
  end

  vlsu_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk          (clk),
    .n_reset      (n_reset),
    .push         (push),
    .push_entry   (new_entry),
    .pop          (head_expired),
    .head         (head),
    .head_expired (head_expired),
    .empty        (fifo_empty),
    .full         (fifo_full)
  );

  // p0: pick the response to issue this cycle
  always_comb begin
    rsp_vld_p0  = head_expired | bypass;
    rsp_data_p0 = 32'd0;
    if (bypass)                            rsp_data_p0 = new_entry.data;
    else if (head_expired && !head.is_write) rsp_data_p0 = head.data;
  end

  // p1: registered response outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      run_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= 32'd0;
    end else begin
      run_q       <= 1'b1;
      lfsr_q      <= lfsr_next(lfsr_q);
      rsp_vld_p1  <= rsp_vld_p0;
      rsp_data_p1 <= rsp_data_p0;
    end
  end

  assign data_rvalid_o = rsp_vld_p1;
  assign data_rdata_o  = rsp_data_p1;

  assign unused_ok = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0], head.lat, head.age};

endmodule

// File: tb/tb_vlsu_data_responder.sv
// Scoreboard bench for vlsu_data_responder: three instances (baseline, tight
// outstanding limit, random latency/grant) driven by directed transactions.
module tb_vlsu_data_responder;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] acc;
    logic [3:0]  lat;
    logic        rnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst  [3];
  logic        req    [3];
  logic        we     [3];
  logic        stall  [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  exp_t        sb [3][$];
  int          last_rv [3];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] shadow [16];
  exp_t        mon_e;
  int          mon_hi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vlsu_data_responder #(.DEPTH_WORDS(1024), .MIN_LATENCY(2), .MAX_OUTSTANDING(4))
  u_dut0 (.clk(clk), .n_reset(n_rst[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
          .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]),
          .data_wdata_i(wdata[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
          .stall_i(stall[0]));

  vlsu_data_responder #(.DEPTH_WORDS(1024), .MIN_LATENCY(4), .MAX_OUTSTANDING(2))
  u_dut1 (.clk(clk), .n_reset(n_rst[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
          .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]),
          .data_wdata_i(wdata[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
          .stall_i(stall[1]));

  vlsu_data_responder #(.DEPTH_WORDS(1024), .MIN_LATENCY(2), .MAX_OUTSTANDING(4),
                        .RANDOM_LAT(1), .RANDOM_GNT(1))
  u_dut2 (.clk(clk), .n_reset(n_rst[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
          .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]),
          .data_wdata_i(wdata[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
          .stall_i(stall[2]));

  function automatic int lmin(input int i);
    return (i == 1) ? 4 : 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] bmask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bmask[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic record(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (n_rst[i] && rvalid[i]) begin
        if (sb[i].size() == 0) begin
          record($sformatf("stray_rvalid_%0d", i), 1'b0, rdata[i], 0);
        end else begin
          mon_e = sb[i].pop_front();
          record($sformatf("rdata_%0d", i), rdata[i] == mon_e.data, rdata[i], mon_e.data);
          if (!mon_e.rnd) begin
            record($sformatf("latency_%0d", i), cyc - int'(mon_e.acc) == int'(mon_e.lat),
                   cyc - int'(mon_e.acc), mon_e.lat);
          end else begin
            mon_hi = int'(mon_e.acc) + int'(mon_e.lat) + 3;
            if (last_rv[i] + 1 > mon_hi) mon_hi = last_rv[i] + 1;
            record($sformatf("rand_latency_%0d", i),
                   (cyc >= int'(mon_e.acc) + int'(mon_e.lat)) && (cyc <= mon_hi),
                   cyc - int'(mon_e.acc), mon_e.lat);
          end
          last_rv[i] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request (leaves req high) and waits, bounded, for its accept
  task automatic do_req(input int i, input logic w, input logic [3:0] bm,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_data, output int waits);
    exp_t e;
    bit   got;
    req[i] = 1'b1; we[i] = w; be[i] = bm; addr[i] = a; wdata[i] = wd;
    waits = 0;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (gnt[i]) begin
        e.data = w ? 32'd0 : exp_data;
        e.acc  = cyc;
        e.lat  = 4'(lmin(i));
        e.rnd  = (i == 2);
        sb[i].push_back(e);
        got = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) record($sformatf("gnt_timeout_%0d", i), 1'b0, 0, 1);
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0; we[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int widx;
    logic        rw;
    logic [3:0]  rb;
    logic [31:0] rd;
    logic [31:0] ra;
    for (int i = 0; i < 3; i++) begin
      n_rst[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; stall[i] = 1'b0;
      be[i] = 4'h0; addr[i] = 32'd0; wdata[i] = 32'd0; last_rv[i] = 0;
    end
    req[0] = 1'b1; req[1] = 1'b1;
    tick(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      record($sformatf("reset_gnt_%0d", i), gnt[i] == 1'b0, gnt[i], 0);
      record($sformatf("reset_rvalid_%0d", i), rvalid[i] == 1'b0, rvalid[i], 0);
      record($sformatf("reset_rdata_%0d", i), rdata[i] == 32'd0, rdata[i], 0);
    end
    @(posedge clk); #1;
    idle(0); idle(1);
    for (int i = 0; i < 3; i++) n_rst[i] = 1'b1;
    tick(3);

    // Write then back-to-back read of the same word
    do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'd0, w);
    do_req(0, 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, w);
    idle(0); tick(4);

    // Partial byte-enable merge
    do_req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'd0, w);
    do_req(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'd0, w);
    do_req(0, 1'b0, 4'h0, 32'h20, 32'd0, 32'h11BB33DD, w);
    idle(0); tick(4);

    // Stall holds off the grant, which rises as soon as stall drops
    stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      record("stall_gnt", gnt[0] == 1'b0, gnt[0], 0);
      @(posedge clk); #1;
    end
    stall[0] = 1'b0;
    do_req(0, 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, w);
    record("gnt_after_stall_waits", w == 0, w, 0);
    idle(0); tick(4);

    // Address aliasing and ignored low address bits
    do_req(0, 1'b1, 4'hF, 32'h0, 32'h55, 32'd0, w);
    do_req(0, 1'b0, 4'h0, 32'h1000, 32'd0, 32'h55, w);
    do_req(0, 1'b0, 4'h0, 32'h3, 32'd0, 32'h55, w);
    idle(0); tick(4);

    // Outstanding limit: 2 entries, latency 4
    for (int k = 0; k < 4; k++) do_req(1, 1'b1, 4'hF, 32'(k * 4), 32'hC0DE0000 + 32'(k), 32'd0, w);
    idle(1); tick(10);
    for (int k = 0; k < 4; k++) begin
      do_req(1, 1'b0, 4'h0, 32'(k * 4), 32'd0, 32'hC0DE0000 + 32'(k), w);
      record($sformatf("full_waits_%0d", k), w == ((k == 2) ? 2 : 0), w, (k == 2) ? 2 : 0);
    end
    idle(1); tick(10);

    // Random latency / grant instance against a shadow memory
    for (int k = 0; k < 16; k++) begin
      shadow[k] = $urandom;
      do_req(2, 1'b1, 4'hF, 32'(k * 4), shadow[k], 32'd0, w);
    end
    idle(2);
    for (int n = 0; n < 200; n++) begin
      if (n == 100) begin
        do_req(2, 1'b0, 4'h0, 32'h0, 32'd0, shadow[0], w);
        do_req(2, 1'b0, 4'h0, 32'h4, 32'd0, shadow[1], w);
        idle(2);
        n_rst[2] = 1'b0;
        sb[2].delete();
        last_rv[2] = 0;
        tick(3);
        n_rst[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          record("post_reset_rvalid", rvalid[2] == 1'b0, rvalid[2], 0);
          @(posedge clk); #1;
        end
      end
      rw   = 1'($urandom_range(0, 1));
      widx = $urandom_range(0, 15);
      rb   = 4'($urandom_range(0, 15));
      rd   = $urandom;
      ra   = 32'(widx * 4) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 12);
      do_req(2, rw, rb, ra, rd, shadow[widx], w);
      if (rw) shadow[widx] = merge(shadow[widx], rd, rb);
      if ($urandom_range(0, 2) == 0) begin
        idle(2);
        tick($urandom_range(1, 2));
      end
    end
    idle(2);
    tick(30);
    for (int i = 0; i < 3; i++)
      record($sformatf("drained_%0d", i), sb[i].size() == 0, sb[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
